// File: rtl/decode_stage.sv
// RV32I decode stage: register file, in-flight scoreboard, hazard detect
// and the registered DE bundle handed to execute.
module decode_stage #(
  parameter int          NUM_REGS = 32,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] FD_pc,
  input  logic [31:0] FD_inst,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        is_data_hazard,
  output logic        DE_valid,
  output logic [31:0] DE_pc,
  output logic [6:0]  DE_opcode,
  output logic [2:0]  DE_funct3,
  output logic        DE_funct7b5,
  output logic [4:0]  DE_rd,
  output logic        DE_reg_we,
  output logic [31:0] DE_rs1_val,
  output logic [31:0] DE_rs2_val,
  output logic [31:0] DE_imm,
  output logic        DE_illegal
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  logic [31:0]         rf_q [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;

  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic is_lui, is_auipc, is_jal, is_jalr, is_br;
  logic is_load, is_store, is_opimm, is_op;
  logic legal, illegal_op, use_rs1, use_rs2, writer;
  logic haz_rs1, haz_rs2, haz_waw, issue;
  logic [31:0] imm, rs1_val, rs2_val;

  assign opc = FD_inst[6:0];
  assign rd  = FD_inst[11:7];
  assign rs1 = FD_inst[19:15];
  assign rs2 = FD_inst[24:20];

  assign is_lui   = opc == OP_LUI;
  assign is_auipc = opc == OP_AUIPC;
  assign is_jal   = opc == OP_JAL;
  assign is_jalr  = opc == OP_JALR;
  assign is_br    = opc == OP_BR;
  assign is_load  = opc == OP_LOAD;
  assign is_store = opc == OP_STORE;
  assign is_opimm = opc == OP_IMM;
  assign is_op    = opc == OP_OP;

  // Opcode 0 is not a legal class, so a bubble is never legal.
  assign legal = is_lui | is_auipc | is_jal | is_jalr | is_br
               | is_load | is_store | is_opimm | is_op;
  assign illegal_op = (FD_inst != 32'd0) && !legal;

  assign use_rs1 = is_jalr | is_br | is_load | is_store
                 | is_opimm | is_op;
  assign use_rs2 = is_br | is_store | is_op;
  assign writer  = (is_lui | is_auipc | is_jal | is_jalr
                 | is_load | is_opimm | is_op) && (rd != 5'd0);

  assign haz_rs1 = use_rs1 && pend_q[rs1]
                && !(wb_en && wb_rd == rs1);
  assign haz_rs2 = use_rs2 && pend_q[rs2]
                && !(wb_en && wb_rd == rs2);
  assign haz_waw = writer && pend_q[rd]
                && !(wb_en && wb_rd == rd);

  assign is_data_hazard = !rst && legal
                       && (haz_rs1 || haz_rs2 || haz_waw);
  assign issue = legal && !is_data_hazard;

  always_comb begin
    imm = 32'd0;
    unique case (1'b1)
      is_lui, is_auipc:
        imm = {FD_inst[31:12], 12'd0};
      is_jal:
        imm = {{12{FD_inst[31]}}, FD_inst[19:12],
               FD_inst[20], FD_inst[30:21], 1'b0};
      is_jalr, is_load, is_opimm:
        imm = {{20{FD_inst[31]}}, FD_inst[31:20]};
      is_store:
        imm = {{20{FD_inst[31]}}, FD_inst[31:25],
               FD_inst[11:7]};
      is_br:
        imm = {{20{FD_inst[31]}}, FD_inst[7],
               FD_inst[30:25], FD_inst[11:8], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  // Write-through: a same-cycle writeback is visible to the reader.
  always_comb begin
    rs1_val = rf_q[rs1];
    if (wb_en && wb_rd == rs1) rs1_val = wb_data;
    if (rs1 == 5'd0) rs1_val = 32'd0;
    rs2_val = rf_q[rs2];
    if (wb_en && wb_rd == rs2) rs2_val = wb_data;
    if (rs2 == 5'd0) rs2_val = 32'd0;
  end

  // Clear first so a same-cycle issue to the same rd keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    if (wb_en && wb_rd != 5'd0) pend_d[wb_rd] = 1'b0;
    if (issue && writer) pend_d[rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wb_en && wb_rd != 5'd0) rf_q[wb_rd] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      DE_valid    <= 1'b0;
      DE_pc       <= RESET_PC;
      DE_opcode   <= 7'd0;
      DE_funct3   <= 3'd0;
      DE_funct7b5 <= 1'b0;
      DE_rd       <= 5'd0;
      DE_reg_we   <= 1'b0;
      DE_rs1_val  <= 32'd0;
      DE_rs2_val  <= 32'd0;
      DE_imm      <= 32'd0;
      DE_illegal  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      if (illegal_op) DE_illegal <= 1'b1;
      if (issue) begin
        DE_valid    <= 1'b1;
        DE_pc       <= FD_pc;
        DE_opcode   <= opc;
        DE_funct3   <= FD_inst[14:12];
        DE_funct7b5 <= FD_inst[30];
        DE_rd       <= writer ? rd : 5'd0;
        DE_reg_we   <= writer;
        DE_rs1_val  <= use_rs1 ? rs1_val : 32'd0;
        DE_rs2_val  <= use_rs2 ? rs2_val : 32'd0;
        DE_imm      <= imm;
      end else begin
        DE_valid    <= 1'b0;
        DE_pc       <= RESET_PC;
        DE_opcode   <= 7'd0;
        DE_funct3   <= 3'd0;
        DE_funct7b5 <= 1'b0;
        DE_rd       <= 5'd0;
        DE_reg_we   <= 1'b0;
        DE_rs1_val  <= 32'd0;
        DE_rs2_val  <= 32'd0;
        DE_imm      <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, RAW/WAW stalls, bypass,
// x0, bubble/illegal, immediates and reset during a stall.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] FD_pc, FD_inst;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        is_data_hazard, DE_valid, DE_funct7b5;
  logic        DE_reg_we, DE_illegal;
  logic [31:0] DE_pc, DE_rs1_val, DE_rs2_val, DE_imm;
  logic [6:0]  DE_opcode;
  logic [2:0]  DE_funct3;
  logic [4:0]  DE_rd;

  int n_cmp = 0;
  int n_err = 0;

  decode_stage dut (
    .clk(clk), .rst(rst), .FD_pc(FD_pc), .FD_inst(FD_inst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .is_data_hazard(is_data_hazard), .DE_valid(DE_valid),
    .DE_pc(DE_pc), .DE_opcode(DE_opcode), .DE_funct3(DE_funct3),
    .DE_funct7b5(DE_funct7b5), .DE_rd(DE_rd),
    .DE_reg_we(DE_reg_we), .DE_rs1_val(DE_rs1_val),
    .DE_rs2_val(DE_rs2_val), .DE_imm(DE_imm),
    .DE_illegal(DE_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] pc,
                         input logic [31:0] inst);
    FD_pc   = pc;
    FD_inst = inst;
    #1;
  endtask

  task automatic wb(input logic en, input logic [4:0] r,
                    input logic [31:0] d);
    wb_en   = en;
    wb_rd   = r;
    wb_data = d;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    FD_pc = 32'h100; FD_inst = 32'h00500293;
    tick(); tick();
    check("rst_valid", 32'(DE_valid), 32'd0);
    check("rst_pc", DE_pc, 32'd0);
    check("rst_haz", 32'(is_data_hazard), 32'd0);
    check("rst_ill", 32'(DE_illegal), 32'd0);

    // ADDI x5,x0,5 issues after reset release
    rst = 1'b0;
    #1;
    check("addi_haz", 32'(is_data_hazard), 32'd0);
    tick();
    check("addi_valid", 32'(DE_valid), 32'd1);
    check("addi_pc", DE_pc, 32'h100);
    check("addi_rd", 32'(DE_rd), 32'd5);
    check("addi_imm", DE_imm, 32'd5);
    check("addi_we", 32'(DE_reg_we), 32'd1);

    // ADD x6,x5,x5 stalls on x5 until writeback
    present(32'h104, 32'h00528333);
    check("raw_haz0", 32'(is_data_hazard), 32'd1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("raw_stall_valid", 32'(DE_valid), 32'd0);
      check("raw_stall_pc", DE_pc, 32'd0);
      check("raw_stall_haz", 32'(is_data_hazard), 32'd1);
    end
    wb(1'b1, 5'd5, 32'd5);
    check("raw_wb_haz", 32'(is_data_hazard), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    check("raw_valid", 32'(DE_valid), 32'd1);
    check("raw_rs1", DE_rs1_val, 32'd5);
    check("raw_rs2", DE_rs2_val, 32'd5);
    check("raw_rd", 32'(DE_rd), 32'd6);
    check("raw_op", 32'(DE_opcode), 32'h33);

    // ADDI x0,x0,1 is not a writer
    present(32'h108, 32'h00100013);
    check("x0_haz", 32'(is_data_hazard), 32'd0);
    tick();
    check("x0_valid", 32'(DE_valid), 32'd1);
    check("x0_we", 32'(DE_reg_we), 32'd0);
    check("x0_rd", 32'(DE_rd), 32'd0);
    // ADD x7,x0,x0 with a writeback aimed at x0
    present(32'h10C, 32'h000003B3);
    wb(1'b1, 5'd0, 32'hFFFF_FFFF);
    check("x0b_haz", 32'(is_data_hazard), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    check("x0b_valid", 32'(DE_valid), 32'd1);
    check("x0b_rs1", DE_rs1_val, 32'd0);
    check("x0b_rs2", DE_rs2_val, 32'd0);
    check("x0b_rd", 32'(DE_rd), 32'd7);

    // bubble then illegal opcode
    present(32'h110, 32'h0);
    check("bub_haz", 32'(is_data_hazard), 32'd0);
    tick();
    check("bub_valid", 32'(DE_valid), 32'd0);
    check("bub_ill", 32'(DE_illegal), 32'd0);
    present(32'h114, 32'h0000007F);
    tick();
    check("ill_valid", 32'(DE_valid), 32'd0);
    check("ill_set", 32'(DE_illegal), 32'd1);
    present(32'h118, 32'h0);
    tick();
    check("ill_sticky", 32'(DE_illegal), 32'd1);

    // LUI x8,0x12345 then WAW on LUI x8,0x1
    present(32'h11C, 32'h12345437);
    tick();
    check("lui_valid", 32'(DE_valid), 32'd1);
    check("lui_imm", DE_imm, 32'h1234_5000);
    present(32'h120, 32'h00001437);
    check("waw_haz", 32'(is_data_hazard), 32'd1);
    tick();
    check("waw_stall", 32'(DE_valid), 32'd0);
    wb(1'b1, 5'd8, 32'hAA);
    check("waw_wb_haz", 32'(is_data_hazard), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    check("waw_valid", 32'(DE_valid), 32'd1);
    check("waw_imm", DE_imm, 32'h0000_1000);
    check("waw_pc", DE_pc, 32'h120);
    // ADD x9,x8,x0 must see x8 still pending
    present(32'h124, 32'h000404B3);
    check("waw_pend", 32'(is_data_hazard), 32'd1);
    wb(1'b1, 5'd8, 32'h55);
    check("waw_pend_wb", 32'(is_data_hazard), 32'd0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    check("byp_rs1", DE_rs1_val, 32'h55);

    // immediates
    present(32'h128, 32'hFE20AE23);
    check("sw_haz", 32'(is_data_hazard), 32'd0);
    tick();
    check("sw_imm", DE_imm, 32'hFFFF_FFFC);
    check("sw_f3", 32'(DE_funct3), 32'd2);
    check("sw_we", 32'(DE_reg_we), 32'd0);
    present(32'h12C, 32'hFE000CE3);
    tick();
    check("beq_imm", DE_imm, 32'hFFFF_FFF8);
    check("beq_valid", 32'(DE_valid), 32'd1);
    present(32'h130, 32'h001000EF);
    tick();
    check("jal_imm", DE_imm, 32'h0000_0800);
    check("jal_rd", 32'(DE_rd), 32'd1);

    // reset in the middle of a stall on x1
    present(32'h134, 32'h00008533);
    check("mid_haz", 32'(is_data_hazard), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_haz", 32'(is_data_hazard), 32'd0);
    tick();
    check("mid_rst_valid", 32'(DE_valid), 32'd0);
    check("mid_rst_ill", 32'(DE_illegal), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_post_haz", 32'(is_data_hazard), 32'd0);
    tick();
    check("mid_valid", 32'(DE_valid), 32'd1);
    check("mid_rd", 32'(DE_rd), 32'd10);
    check("mid_pc", DE_pc, 32'h134);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
